// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline flow controller.
package pipe_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
    } stage_meta_t;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Bubbles must never look like a forwarding source to the hazard unit.
    function automatic stage_meta_t meta_gate(input stage_meta_t m);
        stage_meta_t g;
        g = m;
        if (!m.valid) begin
            g.rd        = 5'd0;
            g.is_load   = 1'b0;
            g.is_store  = 1'b0;
            g.is_branch = 1'b0;
        end
        return g;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: hold (with in-place invalidate), bubble, or load.
module pipe_stage_reg
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        bubble,
    input  logic        clear,
    input  stage_meta_t d,
    output stage_meta_t q
);

    // clear only acts on held contents; a loading stage takes d.valid as-is.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (hold) begin
            q.valid <= q.valid & ~clear;
        end else if (bubble) begin
            q.valid <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Applies hazard-unit stall/invalidate/redirect to the 5-stage pipeline.
// Define PIPE_PERF_CNT_EN to add the retired/stall/flush performance counters.
module pipe_flow_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MAX_STALL = 16
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        inv_if,
    input  logic        inv_id,
    input  logic        inv_ex,
    input  logic        inv_mem,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [4:0]  id_rd,
    input  logic        id_is_load,
    input  logic        id_is_store,
    input  logic        id_is_branch,
    output logic [31:0] if_pc,
    output logic [31:0] id_pc,
    output logic [31:0] ex_pc,
    output logic [31:0] mem_pc,
    output logic        id_valid,
    output logic        ex_valid,
    output logic        mem_valid,
    output logic        wb_valid,
    output logic        ex_invalid,
    output logic        mem_invalid,
    output logic [4:0]  ex_rd,
    output logic [4:0]  mem_rd,
    output logic [4:0]  wb_rd,
    output logic        is_load_ex,
    output logic        is_store_ex,
    output logic        is_branch_ex,
    output logic        is_load_mem,
    output logic        retire,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0] perf_retired,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush,
`endif
    output logic        stall_timeout
);

    logic [31:0] if_pc_q;
    logic        if_valid_q;
    stage_meta_t id_d, ex_d, mem_d, wb_d;
    stage_meta_t id_q, ex_q, mem_q, wb_q;
    stage_meta_t ex_g, mem_g, wb_g;
    logic        id_hold, id_bubble, id_clear;
    logic [7:0]  stall_cnt_q, stall_cnt_nxt;
    logic        timeout_q, retire_q;
    logic [STG_WB:STG_IF] stg_valid;
    logic        unused_meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            if_pc_q    <= RESET_PC;
            if_valid_q <= 1'b0;
        end else begin
            if_valid_q <= 1'b1;
            if (redirect)
                if_pc_q <= redirect_pc;
            else if (!stall_if)
                if_pc_q <= if_pc_q + PC_STEP;
        end
    end

    // stall_id is only meaningful together with stall_if.
    always_comb begin
        id_hold   = stall_if & stall_id;
        id_bubble = stall_if & ~stall_id;
        id_clear  = inv_id | redirect;

        id_d       = '0;
        id_d.valid = if_valid_q & ~inv_if & ~redirect;
        id_d.pc    = if_pc_q;

        ex_d           = '0;
        ex_d.valid     = id_q.valid & ~inv_id;
        ex_d.pc        = id_q.pc;
        ex_d.rd        = id_rd;
        ex_d.is_load   = id_is_load;
        ex_d.is_store  = id_is_store;
        ex_d.is_branch = id_is_branch;

        mem_d       = ex_q;
        mem_d.valid = ex_q.valid & ~inv_ex;

        wb_d       = mem_q;
        wb_d.valid = mem_q.valid & ~inv_mem;
    end

    pipe_stage_reg u_id (
        .clk(clk), .reset(reset), .hold(id_hold), .bubble(id_bubble),
        .clear(id_clear), .d(id_d), .q(id_q)
    );
    pipe_stage_reg u_ex (
        .clk(clk), .reset(reset), .hold(1'b0), .bubble(id_hold),
        .clear(1'b0), .d(ex_d), .q(ex_q)
    );
    pipe_stage_reg u_mem (
        .clk(clk), .reset(reset), .hold(1'b0), .bubble(1'b0),
        .clear(1'b0), .d(mem_d), .q(mem_q)
    );
    pipe_stage_reg u_wb (
        .clk(clk), .reset(reset), .hold(1'b0), .bubble(1'b0),
        .clear(1'b0), .d(wb_d), .q(wb_q)
    );

    always_comb begin
        stall_cnt_nxt = 8'd0;
        if (stall_if && !redirect)
            stall_cnt_nxt = (stall_cnt_q == 8'hFF) ? 8'hFF : stall_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 8'd0;
            timeout_q   <= 1'b0;
            retire_q    <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_nxt;
            retire_q    <= wb_q.valid;
            if (stall_cnt_nxt == 8'(MAX_STALL))
                timeout_q <= 1'b1;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_retired <= 32'd0;
            perf_stall   <= 32'd0;
            perf_flush   <= 32'd0;
        end else begin
            perf_retired <= perf_retired + {31'd0, retire_q};
            perf_stall   <= perf_stall + {31'd0, stall_if};
            perf_flush   <= perf_flush + {31'd0, redirect};
        end
    end
`endif

    assign ex_g  = meta_gate(ex_q);
    assign mem_g = meta_gate(mem_q);
    assign wb_g  = meta_gate(wb_q);

    assign stg_valid[STG_IF]  = if_valid_q;
    assign stg_valid[STG_ID]  = id_q.valid;
    assign stg_valid[STG_EX]  = ex_q.valid;
    assign stg_valid[STG_MEM] = mem_q.valid;
    assign stg_valid[STG_WB]  = wb_q.valid;

    assign if_pc         = if_pc_q;
    assign id_pc         = id_q.pc;
    assign ex_pc         = ex_q.pc;
    assign mem_pc        = mem_q.pc;
    assign id_valid      = stg_valid[STG_ID];
    assign ex_valid      = stg_valid[STG_EX];
    assign mem_valid     = stg_valid[STG_MEM];
    assign wb_valid      = stg_valid[STG_WB];
    assign ex_invalid    = ~stg_valid[STG_EX];
    assign mem_invalid   = ~stg_valid[STG_MEM];
    assign ex_rd         = ex_g.rd;
    assign mem_rd        = mem_g.rd;
    assign wb_rd         = wb_g.rd;
    assign is_load_ex    = ex_g.is_load;
    assign is_store_ex   = ex_g.is_store;
    assign is_branch_ex  = ex_g.is_branch;
    assign is_load_mem   = mem_g.is_load;
    assign retire        = retire_q;
    assign stall_timeout = timeout_q;

    assign unused_meta = ^{stg_valid[STG_IF], id_q.rd, id_q.is_load, id_q.is_store,
                           id_q.is_branch, ex_g.pc, ex_g.valid, mem_g.pc, mem_g.valid,
                           mem_g.is_store, mem_g.is_branch, wb_g.pc, wb_g.valid,
                           wb_g.is_load, wb_g.is_store, wb_g.is_branch};

    a_stall_id_alone: assert property (@(posedge clk) disable iff (reset)
        !(stall_id && !stall_if));

endmodule

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
- Consumes the stall/invalidate/redirect commands from the hazard detection unit and applies them to the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Owns the fetch PC and the per-stage valid bits.
- Owns the per-stage metadata: pc, rd, is_load, is_store, is_branch.
- Returns the per-stage status (EX_invalid, EX_rd, MEM_rd, ...) that the hazard unit consumes, closing the loop.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- MAX_STALL, 16, consecutive stall_if cycles before stall_timeout asserts; legal range 1..255.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- stall_if  in  1  hold IF stage and fetch PC.
- stall_id  in  1  hold ID stage; the ID-side hold is honoured only while stall_if=1 (stall_id alone: see Behaviour).
- inv_if / inv_id / inv_ex / inv_mem  in  1 each  discard the instruction leaving that stage.
- redirect  in  1  took_branch / exception / ret redirect.
- redirect_pc  in  32  new fetch PC.
- id_rd  in  5  decoded destination register.
- id_is_load / id_is_store / id_is_branch  in  1 each  decoded class.
- if_pc  out  32  current fetch PC.
- id_pc / ex_pc / mem_pc  out  32  stage PCs.
- id_valid / ex_valid / mem_valid / wb_valid  out  1 each  stage valid bits.
- ex_invalid / mem_invalid  out  1 each  ~ex_valid / ~mem_valid.
- ex_rd / mem_rd / wb_rd  out  5 each  stage rd; forced 0 when stage invalid.
- is_load_ex / is_store_ex / is_branch_ex / is_load_mem  out  1 each  gated by valid.
- retire  out  1  one-cycle pulse when a valid instruction leaves WB.
- stall_timeout  out  1  sticky error flag.

Behaviour:
- Reset (synchronous): if_pc=RESET_PC; all valid=0; all stage pc/rd/class=0; retire=0; stall_timeout=0; stall counter=0.
- Reset overrides every other input in the same cycle, including mid-stall or mid-redirect.
- Fetch PC next value, priority order:
  - redirect → redirect_pc;
  - else stall_if → hold;
  - else if_pc+4 (32-bit wrap: 32'hFFFF_FFFC+4 = 0).
- if_valid is internal. It is 0 for exactly one cycle after reset, and 1 otherwise.
- Stage advance (per edge, no reset):
  - ID ← IF: if stall_if, ID holds. Otherwise ID takes (if_pc, if_valid & ~inv_if & ~redirect).
  - EX ← ID: if stall_if & stall_id, EX valid=0 (bubble) and ID holds. If stall_if & ~stall_id, EX advances with ID contents and ID valid becomes 0 (ID bubble). Otherwise EX takes ID contents with valid = id_valid & ~inv_id.
  - MEM ← EX: always advances; valid = ex_valid & ~inv_ex.
  - WB ← MEM: always advances; valid = mem_valid & ~inv_mem.
- stall_id without stall_if is illegal. It is treated as no stall, and an assertion flags it.
- inv_* beats stall: an invalidated stage that is also held has its valid cleared in place.
- Metadata (pc, rd, class bits) moves with its valid bit. Invalid stages drive rd=0 and class outputs=0 so the hazard unit never forwards from a bubble.
- retire registered: retire = wb_valid, valid during the cycle after WB entry.
- Stall counter, 8-bit:
  - increments while stall_if=1 & ~redirect;
  - clears otherwise;
  - saturates at 255.
  - stall_timeout sets when counter == MAX_STALL and stays set until reset.
- Simultaneous redirect + stall_if: redirect wins for the PC, and the instruction entering ID is invalid.

Optional Feature:
- PIPE_PERF_CNT_EN defined: adds outputs perf_retired, perf_stall, perf_flush, each 32 bits.
  - Counters reset to 0 and wrap at 2^32.
  - perf_retired increments per retire pulse.
  - perf_stall increments per stall_if cycle.
  - perf_flush increments per redirect cycle.
- Not defined: ports absent, no counter logic.

Decomposition:
- Shared package pipe_pkg:
  - stage_meta_t struct {valid, pc[31:0], rd[4:0], is_load, is_store, is_branch};
  - stage index constants STG_IF..STG_WB;
  - PC_STEP=4.
- Sub-module pipe_stage_reg: one stage_meta_t register with hold, bubble and clear controls and synchronous reset. Instantiated for ID, EX, MEM, WB.

Test Plan:
- Reset then run 5 cycles, no stalls → if_pc 0,4,8,12,16; wb_valid first rises on cycle 5; retire pulses from cycle 6.
- id_rd=5 with id_is_load=1, then stall_if=stall_id=1 for 1 cycle → ID and if_pc hold; ex_valid=0 (bubble); ex_rd=0; mem_rd=5, is_load_mem=1 next.
- redirect=1, redirect_pc=32'h100, inv_if/inv_id/inv_ex/inv_mem=1 → next cycle if_pc=32'h100; id/ex/mem/wb valid all 0; perf_flush+1 when enabled.
- Redirect and stall_if asserted together → if_pc=redirect_pc; id_valid=0.
- Hold stall_if=1 for MAX_STALL=16 cycles → stall_timeout=1 on cycle 16, stays 1 after stall drops, clears only on reset.
- if_pc=32'hFFFF_FFFC, no stall → wraps to 0; reset mid-stall clears all valids and sets if_pc=RESET_PC.
